// File: rtl/tick_timebase_if.sv
// Handshake bundle for tick_timebase: control inputs plus the registered
// tick/count/wrap_pulse outputs. master = controller side, slave = timebase.
interface tick_timebase_if #(
  parameter int unsigned CNT_W = 4
);
  logic             enable;
  logic             down;
  logic             wrap_ld;
  logic [CNT_W-1:0] wrap_val;
  logic             tick;
  logic [CNT_W-1:0] count;
  logic             wrap_pulse;

  modport master (
    output enable, down, wrap_ld, wrap_val,
    input  tick, count, wrap_pulse
  );

  modport slave (
    input  enable, down, wrap_ld, wrap_val,
    output tick, count, wrap_pulse
  );
endinterface

// File: rtl/tick_timebase.sv
// Prescaled tick generator driving a programmable-modulus up/down counter.
// Define TIMEBASE_FAST_SIM_EN to use SIM_DIV as the prescale divisor.
module tick_timebase #(
  parameter int unsigned CLK_HZ   = 50_000_000,
  parameter int unsigned TICK_HZ  = 1,
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned WRAP_RST = 8,
  parameter int unsigned SIM_DIV  = 10
) (
  input  logic               CLOCK,
  input  logic               clr,
  tick_timebase_if.slave     bus
);

`ifdef TIMEBASE_FAST_SIM_EN
  localparam int unsigned DIV = SIM_DIV;
`else
  localparam int unsigned DIV = (TICK_HZ > 0) ? CLK_HZ / TICK_HZ : 0;
`endif
  localparam int unsigned PW = (DIV > 2) ? $clog2(DIV) : 1;

  if (TICK_HZ == 0) begin : g_chk_tick_hz
    $fatal(1, "tick_timebase: TICK_HZ must be > 0");
  end
  if (DIV < 2) begin : g_chk_div
    $fatal(1, "tick_timebase: prescale divisor must be >= 2");
  end
  if ((WRAP_RST < 1) || (longint'(WRAP_RST) > (longint'(1) << CNT_W))) begin : g_chk_wrap
    $fatal(1, "tick_timebase: WRAP_RST must be in 1..2**CNT_W");
  end

  localparam logic [PW-1:0]    PRE_LAST   = PW'(DIV - 1);
  localparam logic [CNT_W-1:0] WRAP_M1_RST = CNT_W'(WRAP_RST - 1);

  logic [PW-1:0]    pre_cnt;
  // Modulus is held as (modulus-1) so 2**CNT_W still fits in CNT_W bits.
  logic [CNT_W-1:0] wrap_m1;
  logic [CNT_W-1:0] count_q;
  logic             tick_q;
  logic             wrap_q;

  logic             wrap_hit;
  logic [CNT_W-1:0] count_adv;
  logic             load_ok;

  always_comb begin
    wrap_hit  = bus.down ? (count_q == '0) : (count_q == wrap_m1);
    count_adv = '0;
    if (wrap_hit) begin
      count_adv = bus.down ? wrap_m1 : '0;
    end else begin
      count_adv = bus.down ? (count_q - 1'b1) : (count_q + 1'b1);
    end
    load_ok = bus.wrap_ld && (bus.wrap_val != '0);
  end

  always_ff @(posedge CLOCK) begin
    if (clr) begin
      pre_cnt <= '0;
      count_q <= '0;
      wrap_m1 <= WRAP_M1_RST;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else if (load_ok) begin
      wrap_m1 <= bus.wrap_val - 1'b1;
      count_q <= '0;
      pre_cnt <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else if (bus.enable) begin
      if (pre_cnt == PRE_LAST) begin
        pre_cnt <= '0;
        tick_q  <= 1'b1;
        count_q <= count_adv;
        wrap_q  <= wrap_hit;
      end else begin
        pre_cnt <= pre_cnt + 1'b1;
        tick_q  <= 1'b0;
        wrap_q  <= 1'b0;
      end
    end else begin
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end
  end

  assign bus.tick       = tick_q;
  assign bus.count      = count_q;
  assign bus.wrap_pulse = wrap_q;

endmodule

// File: tb/tb_tick_timebase.sv
// Directed self-checking bench for tick_timebase with a divisor of 10
// (CLK_HZ=20, TICK_HZ=2, SIM_DIV=10) and modulus 8 after reset.
module tb_tick_timebase;
  logic CLOCK;
  logic clr;
  int unsigned tests_run;
  int unsigned tests_failed;

  tick_timebase_if #(.CNT_W(4)) bus ();

  tick_timebase #(
    .CLK_HZ(20),
    .TICK_HZ(2),
    .CNT_W(4),
    .WRAP_RST(8),
    .SIM_DIV(10)
  ) dut (
    .CLOCK(CLOCK),
    .clr(clr),
    .bus(bus)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  task automatic cyc();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic do_clr(input logic dn);
    clr = 1'b1;
    bus.enable = 1'b1;
    bus.down = dn;
    bus.wrap_ld = 1'b0;
    bus.wrap_val = '0;
    cyc();
    cyc();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b1;
    bus.enable = 1'b1;
    bus.wrap_ld = 1'b1;
    bus.wrap_val = 4'd5;
    for (int i = 0; i < 2; i++) begin
      cyc();
      tests_run++;
      if (bus.tick !== 1'b0 || bus.count !== 4'd0 || bus.wrap_pulse !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset: tick=%0b count=%0d wrap_pulse=%0b, expected 0/0/0",
                 bus.tick, bus.count, bus.wrap_pulse);
      end
    end
    bus.wrap_ld = 1'b0;
  endtask

  task automatic test_count_up();
    logic e_tick, e_wp;
    logic [3:0] e_cnt;
    do_clr(1'b0);
    for (int n = 1; n <= 100; n++) begin
      cyc();
      e_tick = (n % 10 == 0);
      e_cnt  = 4'((n / 10) % 8);
      e_wp   = e_tick && (e_cnt == 4'd0);
      tests_run++;
      if (bus.tick !== e_tick || bus.count !== e_cnt || bus.wrap_pulse !== e_wp) begin
        tests_failed++;
        $display("FAIL count_up cyc%0d: tick=%0b count=%0d wp=%0b, expected %0b/%0d/%0b",
                 n, bus.tick, bus.count, bus.wrap_pulse, e_tick, e_cnt, e_wp);
      end
    end
  endtask

  task automatic test_pause();
    do_clr(1'b0);
    for (int n = 0; n < 4; n++) cyc();
    bus.enable = 1'b0;
    for (int n = 1; n <= 7; n++) begin
      cyc();
      tests_run++;
      if (bus.tick !== 1'b0 || bus.count !== 4'd0 || bus.wrap_pulse !== 1'b0) begin
        tests_failed++;
        $display("FAIL pause cyc%0d: tick=%0b count=%0d wp=%0b, expected 0/0/0",
                 n, bus.tick, bus.count, bus.wrap_pulse);
      end
    end
    bus.enable = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      cyc();
      tests_run++;
      if (bus.tick !== (n == 6) || bus.count !== ((n == 6) ? 4'd1 : 4'd0)) begin
        tests_failed++;
        $display("FAIL resume cyc%0d: tick=%0b count=%0d, expected %0b/%0d",
                 n, bus.tick, bus.count, (n == 6), (n == 6) ? 1 : 0);
      end
    end
  endtask

  task automatic test_count_down();
    logic e_tick, e_wp;
    logic [3:0] e_cnt;
    int k;
    do_clr(1'b1);
    for (int n = 1; n <= 90; n++) begin
      cyc();
      k = n / 10;
      e_tick = (n % 10 == 0);
      e_cnt  = 4'((8 - (k % 8)) % 8);
      e_wp   = e_tick && (k % 8 == 1);
      tests_run++;
      if (bus.tick !== e_tick || bus.count !== e_cnt || bus.wrap_pulse !== e_wp) begin
        tests_failed++;
        $display("FAIL count_down cyc%0d: tick=%0b count=%0d wp=%0b, expected %0b/%0d/%0b",
                 n, bus.tick, bus.count, bus.wrap_pulse, e_tick, e_cnt, e_wp);
      end
    end
    // direction flipped mid-period takes effect at the next tick
    do_clr(1'b0);
    for (int n = 0; n < 15; n++) cyc();
    bus.down = 1'b1;
    for (int n = 0; n < 5; n++) cyc();
    tests_run++;
    if (bus.tick !== 1'b1 || bus.count !== 4'd0 || bus.wrap_pulse !== 1'b0) begin
      tests_failed++;
      $display("FAIL down_midperiod: tick=%0b count=%0d wp=%0b, expected 1/0/0",
               bus.tick, bus.count, bus.wrap_pulse);
    end
    for (int n = 0; n < 10; n++) cyc();
    tests_run++;
    if (bus.tick !== 1'b1 || bus.count !== 4'd7 || bus.wrap_pulse !== 1'b1) begin
      tests_failed++;
      $display("FAIL down_underflow: tick=%0b count=%0d wp=%0b, expected 1/7/1",
               bus.tick, bus.count, bus.wrap_pulse);
    end
    bus.down = 1'b0;
  endtask

  task automatic test_wrap_load();
    logic e_tick, e_wp;
    logic [3:0] e_cnt;
    do_clr(1'b0);
    for (int n = 0; n < 59; n++) cyc();
    tests_run++;
    if (bus.count !== 4'd5 || bus.tick !== 1'b0) begin
      tests_failed++;
      $display("FAIL preload: count=%0d tick=%0b, expected 5/0", bus.count, bus.tick);
    end
    bus.wrap_ld = 1'b1;
    bus.wrap_val = 4'd3;
    cyc();
    bus.wrap_ld = 1'b0;
    tests_run++;
    if (bus.tick !== 1'b0 || bus.count !== 4'd0 || bus.wrap_pulse !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_edge: tick=%0b count=%0d wp=%0b, expected 0/0/0",
               bus.tick, bus.count, bus.wrap_pulse);
    end
    for (int n = 1; n <= 40; n++) begin
      // final period holds wrap_ld high with wrap_val=0, which must be ignored
      if (n == 31) begin
        bus.wrap_ld = 1'b1;
        bus.wrap_val = 4'd0;
      end
      cyc();
      e_tick = (n % 10 == 0);
      e_cnt  = 4'((n / 10) % 3);
      e_wp   = e_tick && (e_cnt == 4'd0);
      tests_run++;
      if (bus.tick !== e_tick || bus.count !== e_cnt || bus.wrap_pulse !== e_wp) begin
        tests_failed++;
        $display("FAIL wrap3 cyc%0d: tick=%0b count=%0d wp=%0b, expected %0b/%0d/%0b",
                 n, bus.tick, bus.count, bus.wrap_pulse, e_tick, e_cnt, e_wp);
      end
    end
    bus.wrap_ld = 1'b0;
  endtask

  task automatic test_wrap_one();
    do_clr(1'b0);
    bus.wrap_ld = 1'b1;
    bus.wrap_val = 4'd1;
    cyc();
    bus.wrap_ld = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      cyc();
      tests_run++;
      if (bus.tick !== (n % 10 == 0) || bus.count !== 4'd0 || bus.wrap_pulse !== (n % 10 == 0)) begin
        tests_failed++;
        $display("FAIL wrap1 cyc%0d: tick=%0b count=%0d wp=%0b, expected %0b/0/%0b",
                 n, bus.tick, bus.count, bus.wrap_pulse, (n % 10 == 0), (n % 10 == 0));
      end
    end
  endtask

  task automatic test_clr_over_load();
    logic e_tick, e_wp;
    logic [3:0] e_cnt;
    do_clr(1'b0);
    for (int n = 0; n < 25; n++) cyc();
    clr = 1'b1;
    bus.wrap_ld = 1'b1;
    bus.wrap_val = 4'd3;
    cyc();
    clr = 1'b0;
    bus.wrap_ld = 1'b0;
    tests_run++;
    if (bus.tick !== 1'b0 || bus.count !== 4'd0 || bus.wrap_pulse !== 1'b0) begin
      tests_failed++;
      $display("FAIL clr_ld_edge: tick=%0b count=%0d wp=%0b, expected 0/0/0",
               bus.tick, bus.count, bus.wrap_pulse);
    end
    for (int n = 1; n <= 80; n++) begin
      cyc();
      e_tick = (n % 10 == 0);
      e_cnt  = 4'((n / 10) % 8);
      e_wp   = e_tick && (e_cnt == 4'd0);
      tests_run++;
      if (bus.tick !== e_tick || bus.count !== e_cnt || bus.wrap_pulse !== e_wp) begin
        tests_failed++;
        $display("FAIL clr_ld_mod8 cyc%0d: tick=%0b count=%0d wp=%0b, expected %0b/%0d/%0b",
                 n, bus.tick, bus.count, bus.wrap_pulse, e_tick, e_cnt, e_wp);
      end
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    clr = 1'b1;
    bus.enable = 1'b0;
    bus.down = 1'b0;
    bus.wrap_ld = 1'b0;
    bus.wrap_val = '0;
    test_reset();
    test_count_up();
    test_pause();
    test_count_down();
    test_wrap_load();
    test_wrap_one();
    test_clr_over_load();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
